// File: rtl/light_color_vote_ctrl.sv
// rtl/light_color_vote_ctrl.sv - frame-level red/green vote counter, candidate picker and debouncer
//
// Purpose: counts ROI-gated, saturation/value-gated classifier votes per frame,
// picks a frame candidate at frame end and debounces it into light_state.
//
// Ports:
//   clk, reset              pixel clock, synchronous active-high reset
//   frame_start, frame_end  one-cycle frame delimiters
//   pixel_valid, x_pixel, y_pixel, r_g_decision, s_data, v_data
//                           per-pixel classifier results
//   light_state             debounced state: 0 red, 1 green, 2 none
//   state_change            one-cycle pulse when light_state changes
//   decision_valid          one-cycle pulse when a frame decision completes
//   red_votes, green_votes  final counts of the last completed frame
//                           (only when LIGHT_VOTE_STATS_EN is defined)
//
// Optional feature macro: LIGHT_VOTE_STATS_EN

module light_color_vote_ctrl #(
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 319,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 239,
    parameter int S_MIN      = 64,
    parameter int V_MIN      = 64,
    parameter int PIX_THRESH = 200,
    parameter int DEBOUNCE   = 3,
    parameter int CNT_W      = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pixel_valid,
    input  logic [9:0]       x_pixel,
    input  logic [8:0]       y_pixel,
    input  logic [1:0]       r_g_decision,
    input  logic [7:0]       s_data,
    input  logic [7:0]       v_data,
    output logic [1:0]       light_state,
    output logic             state_change,
    output logic             decision_valid
`ifdef LIGHT_VOTE_STATS_EN
    ,
    output logic [CNT_W-1:0] red_votes,
    output logic [CNT_W-1:0] green_votes
`endif
);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        ACCUM,
        DECIDE,
        UPDATE
    } state_t;

    localparam logic [1:0] COL_RED   = 2'd0;
    localparam logic [1:0] COL_GREEN = 2'd1;
    localparam logic [1:0] COL_NONE  = 2'd2;

    localparam int               SW     = $clog2(DEBOUNCE + 1);
    localparam logic [SW-1:0]    DB     = SW'(DEBOUNCE);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(PIX_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic [CNT_W-1:0]  red_cnt;
    logic [CNT_W-1:0]  green_cnt;
    logic [1:0]        cand;
    logic [1:0]        prev_cand;
    logic [SW-1:0]     stable_cnt;

    logic              pix_vote;
    logic              red_vote;
    logic              green_vote;
    logic [CNT_W-1:0]  red_inc;
    logic [CNT_W-1:0]  green_inc;
    logic [SW-1:0]     stable_next;

    // Signed int comparisons keep the gate well-formed when a bound is 0.
    always_comb begin
        pix_vote = pixel_valid
                && (int'(x_pixel) >= X_MIN) && (int'(x_pixel) <= X_MAX)
                && (int'(y_pixel) >= Y_MIN) && (int'(y_pixel) <= Y_MAX)
                && (int'(s_data)  >= S_MIN) && (int'(v_data)  >= V_MIN);
        red_vote   = pix_vote && (r_g_decision == COL_RED);
        green_vote = pix_vote && (r_g_decision == COL_GREEN);
    end

    // Saturating increments: a full counter holds its value.
    assign red_inc   = (red_cnt   == CNT_MAX) ? red_cnt   : red_cnt   + 1'b1;
    assign green_inc = (green_cnt == CNT_MAX) ? green_cnt : green_cnt + 1'b1;

    // Run length of the current candidate, clamped at DEBOUNCE.
    always_comb begin
        stable_next = SW'(1);
        if (cand == prev_cand) begin
            stable_next = (stable_cnt >= DB) ? DB : stable_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= WAIT_FRAME;
            red_cnt        <= '0;
            green_cnt      <= '0;
            cand           <= COL_NONE;
            prev_cand      <= COL_NONE;
            stable_cnt     <= '0;
            light_state    <= COL_NONE;
            state_change   <= 1'b0;
            decision_valid <= 1'b0;
`ifdef LIGHT_VOTE_STATS_EN
            red_votes      <= '0;
            green_votes    <= '0;
`endif
        end else begin
            state_change   <= 1'b0;
            decision_valid <= 1'b0;
            case (state)
                WAIT_FRAME: begin
                    if (frame_start) begin
                        red_cnt   <= '0;
                        green_cnt <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (frame_start && !frame_end) begin
                        // Restart: partial counts dropped, this cycle's pixel seeds the new frame.
                        red_cnt   <= {{(CNT_W-1){1'b0}}, red_vote};
                        green_cnt <= {{(CNT_W-1){1'b0}}, green_vote};
                    end else begin
                        if (red_vote)   red_cnt   <= red_inc;
                        if (green_vote) green_cnt <= green_inc;
                        if (frame_end)  state     <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (red_cnt >= THRESH && red_cnt > green_cnt) begin
                        cand <= COL_RED;
                    end else if (green_cnt >= THRESH && green_cnt > red_cnt) begin
                        cand <= COL_GREEN;
                    end else begin
                        cand <= COL_NONE;
                    end
                    state <= UPDATE;
                end
                UPDATE: begin
                    prev_cand      <= cand;
                    stable_cnt     <= stable_next;
                    decision_valid <= 1'b1;
                    if (stable_next >= DB && cand != light_state) begin
                        light_state  <= cand;
                        state_change <= 1'b1;
                    end
`ifdef LIGHT_VOTE_STATS_EN
                    red_votes   <= red_cnt;
                    green_votes <= green_cnt;
`endif
                    state <= WAIT_FRAME;
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_light_color_vote_ctrl.sv
// tb/tb_light_color_vote_ctrl.sv - self-checking bench for light_color_vote_ctrl

module tb_light_color_vote_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       frame_end;
    logic       pixel_valid;
    logic [9:0] x_pixel;
    logic [8:0] y_pixel;
    logic [1:0] r_g_decision;
    logic [7:0] s_data;
    logic [7:0] v_data;
    logic [1:0] light_state;
    logic       state_change;
    logic       decision_valid;

    light_color_vote_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .pixel_valid    (pixel_valid),
        .x_pixel        (x_pixel),
        .y_pixel        (y_pixel),
        .r_g_decision   (r_g_decision),
        .s_data         (s_data),
        .v_data         (v_data),
        .light_state    (light_state),
        .state_change   (state_change),
        .decision_valid (decision_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int MAXC = (1 << 17) - 1;

    // Frame-level model
    int  checks = 0;
    int  errors = 0;
    int  sc_seen = 0;
    int  dv_seen = 0;
    bit  m_acc;
    int  m_red, m_green;
    bit  pend;
    int  due, fr, fg;
    int  exp_light;
    int  hist[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_acc = 0; m_red = 0; m_green = 0; pend = 0; exp_light = 2;
        hist.delete();
    endtask

    task automatic model_count(input bit votes, input logic [1:0] dec);
        if (votes && dec == 2'd0) m_red   = (m_red   < MAXC) ? m_red + 1   : MAXC;
        if (votes && dec == 2'd1) m_green = (m_green < MAXC) ? m_green + 1 : MAXC;
    endtask

    // Drive one cycle and advance the model from the spec's frame rules.
    task automatic pix(input logic [1:0] dec, input int x, input int y, input int s,
                       input bit pv, input bit fs, input bit fe);
        bit votes;
        frame_start = fs; frame_end = fe; pixel_valid = pv;
        x_pixel = 10'(x); y_pixel = 9'(y); r_g_decision = dec;
        s_data = 8'(s); v_data = 8'(200);
        votes = pv && x >= 0 && x <= 319 && y >= 0 && y <= 239 && s >= 64;
        if (fe && m_acc) begin
            model_count(votes, dec);
            m_acc = 0; pend = 1; due = cyc + 3; fr = m_red; fg = m_green;
        end else if (fs) begin
            if (m_acc) begin
                m_red = 0; m_green = 0;
                model_count(votes, dec);
            end else begin
                m_acc = 1; m_red = 0; m_green = 0;
            end
        end else if (m_acc) begin
            model_count(votes, dec);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(2'd2, 0, 0, 0, 0, 0, 0);
    endtask

    // Frame: start cycle, nr red then ng green pixels, frame_end on the last pixel.
    task automatic frame(input int nr, input int ng, input int xoff, input int s);
        int n;
        n = nr + ng;
        pix(2'd2, 0, 0, 0, 0, 1, 0);
        if (n == 0) pix(2'd2, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < n; i++)
            pix((i < nr) ? 2'd0 : 2'd1, xoff + (i % 300), (i / 300) % 240, s, 1, 0, i == n - 1);
    endtask

    task automatic apply_reset(input int n);
        reset = 1;
        frame_start = 0; frame_end = 0; pixel_valid = 0;
        model_clear();
        repeat (n) tick();
        reset = 0;
    endtask

    task automatic compare_loop();
        int exp_sc, exp_dv, c;
        bit same;
        forever begin
            @(negedge clk);
            exp_sc = 0; exp_dv = 0;
            if (pend && cyc == due) begin
                pend = 0; exp_dv = 1;
                c = (fr >= 200 && fr > fg) ? 0 : (fg >= 200 && fg > fr) ? 1 : 2;
                hist.push_back(c);
                if (hist.size() > 3) void'(hist.pop_front());
                same = (hist.size() == 3);
                foreach (hist[k]) if (hist[k] != c) same = 0;
                if (same && c != exp_light) begin
                    exp_light = c; exp_sc = 1;
                end
            end
            if (!reset) begin
                check("light_state", int'(light_state), exp_light);
                check("state_change", int'(state_change), exp_sc);
                check("decision_valid", int'(decision_valid), exp_dv);
                if (state_change) sc_seen++;
                if (decision_valid) dv_seen++;
            end
        end
    endtask

    initial begin
        frame_start = 0; frame_end = 0; pixel_valid = 0;
        x_pixel = 0; y_pixel = 0; r_g_decision = 2'd2; s_data = 0; v_data = 0;
        reset = 1;
        model_clear();
        fork
            compare_loop();
        join_none
        repeat (3) tick();
        reset = 0;
        idle(2);
        check("lit_reset_light", int'(light_state), 2);
        check("lit_reset_dv", int'(decision_valid), 0);

        // Two empty frames
        frame(0, 0, 0, 200); idle(4);
        frame(0, 0, 0, 200); idle(4);
        check("lit_empty_dv_count", dv_seen, 2);
        check("lit_empty_sc_count", sc_seen, 0);

        // Three red-majority frames: change only after the third
        frame(300, 50, 0, 200); idle(4);
        frame(300, 50, 0, 200); idle(4);
        check("lit_red2_light", int'(light_state), 2);
        frame(300, 50, 0, 200); idle(4);
        check("lit_red3_light", int'(light_state), 0);
        check("lit_red3_sc_count", sc_seen, 1);

        // Red, red, green, green, green
        frame(300, 0, 0, 200); idle(4);
        frame(300, 0, 0, 200); idle(4);
        frame(0, 300, 0, 200); idle(4);
        check("lit_green1_light", int'(light_state), 0);
        frame(0, 300, 0, 200); idle(4);
        frame(0, 300, 0, 200); idle(4);
        check("lit_green3_light", int'(light_state), 1);
        check("lit_green3_sc_count", sc_seen, 2);

        // Gated-out pixels: outside ROI, then saturation one below minimum
        frame(300, 0, 320, 200); idle(4);
        frame(300, 0, 0, 63); idle(4);
        check("lit_gated_light", int'(light_state), 1);

        // Tie (third none candidate in a row flips to none), then below threshold
        frame(250, 250, 0, 200); idle(4);
        check("lit_tie_light", int'(light_state), 2);
        frame(199, 0, 0, 200); idle(4);
        check("lit_below_thresh_sc_count", sc_seen, 3);

        // Mid-frame restart: 250 red discarded, restart pixel plus 199 green = 200 green
        for (int f = 0; f < 3; f++) begin
            pix(2'd2, 0, 0, 0, 0, 1, 0);
            for (int i = 0; i < 250; i++) pix(2'd0, i, 0, 200, 1, 0, 0);
            pix(2'd1, 0, 1, 200, 1, 1, 0);
            for (int i = 0; i < 199; i++) pix(2'd1, i, 2, 200, 1, 0, i == 198);
            idle(4);
        end
        check("lit_restart_light", int'(light_state), 1);
        check("lit_restart_sc_count", sc_seen, 4);

        // Reset during UPDATE of the frame that would have switched to red
        frame(300, 0, 0, 200); idle(4);
        frame(300, 0, 0, 200); idle(4);
        frame(300, 0, 0, 200);
        idle(1);
        apply_reset(2);
        idle(4);
        check("lit_upd_reset_light", int'(light_state), 2);
        check("lit_upd_reset_sc_count", sc_seen, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
